// File: rtl/axi_burst_mem_slave.sv
// AXI-style burst memory slave: independent AR/R and AW/W/B engines sharing one word array.
// Read data is fetched into the output register the edge before it is presented.
module axi_burst_mem_slave #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [LEN_W-1:0]  ar_len,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [ID_W-1:0]   r_id,
  output logic [1:0]        r_resp,
  output logic              r_last,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [LEN_W-1:0]  aw_len,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [ID_W-1:0]   b_id,
  output logic [1:0]        b_resp
);

  localparam int unsigned AX_W  = ADDR_W + 1;
  localparam int unsigned CNT_W = LEN_W + 1;
  localparam logic [AX_W-1:0] DEPTH_X     = AX_W'(MEM_DEPTH);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [AX_W-1:0]   r_addr_q, r_addr_d;
  logic [LEN_W-1:0]  r_len_q, r_len_d;
  logic [LEN_W-1:0]  r_cnt_q, r_cnt_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic              r_last_q, r_last_d;
  logic              r_fetch_c;
  logic              ar_ready_q, r_valid_q;

  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [AX_W-1:0]   w_addr_q, w_addr_d;
  logic [LEN_W-1:0]  w_len_q, w_len_d;
  logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
  logic              w_err_q, w_err_d;
  logic [ID_W-1:0]   b_id_q, b_id_d;
  logic [1:0]        b_resp_q, b_resp_d;
  logic              mem_we_c;
  logic              aw_ready_q, w_ready_q, b_valid_q;

  // Read engine: latch burst on AR, fetch the next beat on each accepted R beat
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    r_fetch_c = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_valid && ar_ready_q) begin
          r_id_d    = ar_id;
          r_addr_d  = AX_W'(ar_addr);
          r_len_d   = ar_len;
          r_cnt_d   = '0;
          r_last_d  = (ar_len == '0);
          r_fetch_c = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_valid_q && r_ready) begin
          if (r_last_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d  = r_addr_q + AX_W'(1);
            r_cnt_d   = r_cnt_q + LEN_W'(1);
            r_last_d  = (r_cnt_d == r_len_q);
            r_fetch_c = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Registered fetch sees the array before any write landing on the same edge
    if (r_fetch_c) begin
      if (r_addr_d < DEPTH_X) begin
        r_data_d = mem_q[r_addr_d[ADDR_W-1:0]];
        r_resp_d = RESP_OKAY;
      end else begin
        r_data_d = '0;
        r_resp_d = RESP_SLVERR;
      end
    end
  end

  // Write engine: beat counter saturates at len+1 so surplus beats are recognised and dropped
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    b_id_d    = b_id_q;
    b_resp_d  = b_resp_q;
    mem_we_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_valid && aw_ready_q) begin
          w_id_d    = aw_id;
          w_addr_d  = AX_W'(aw_addr);
          w_len_d   = aw_len;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_valid && w_ready_q) begin
          if (w_cnt_q <= CNT_W'(w_len_q)) begin
            if (w_addr_q < DEPTH_X) mem_we_c = 1'b1;
            else                    w_err_d  = 1'b1;
          end else begin
            w_err_d = 1'b1;
          end
          if (w_last) begin
            if (w_cnt_q < CNT_W'(w_len_q)) w_err_d = 1'b1;
            b_id_d    = w_id_q;
            b_resp_d  = w_err_d ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else if (w_cnt_q <= CNT_W'(w_len_q)) begin
            w_cnt_d  = w_cnt_q + CNT_W'(1);
            w_addr_d = w_addr_q + AX_W'(1);
          end
        end
      end
      W_RESP: begin
        if (b_valid_q && b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      w_state_q  <= W_IDLE;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_addr_q   <= r_addr_d;
      r_len_q    <= r_len_d;
      r_cnt_q    <= r_cnt_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
      ar_ready_q <= (r_state_d == R_IDLE);
      r_valid_q  <= (r_state_d == R_DATA);
      w_state_q  <= w_state_d;
      w_id_q     <= w_id_d;
      w_addr_q   <= w_addr_d;
      w_len_q    <= w_len_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      b_id_q     <= b_id_d;
      b_resp_q   <= b_resp_d;
      aw_ready_q <= (w_state_d == W_IDLE);
      w_ready_q  <= (w_state_d == W_DATA);
      b_valid_q  <= (w_state_d == W_RESP);
    end
  end

  // Storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[w_addr_q[ADDR_W-1:0]] <= w_data;
  end

  assign ar_ready = ar_ready_q;
  assign r_valid  = r_valid_q;
  assign r_data   = r_data_q;
  assign r_id     = r_id_q;
  assign r_resp   = r_resp_q;
  assign r_last   = r_last_q;
  assign aw_ready = aw_ready_q;
  assign w_ready  = w_ready_q;
  assign b_valid  = b_valid_q;
  assign b_id     = b_id_q;
  assign b_resp   = b_resp_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomised bench for axi_burst_mem_slave against an array-based memory model.
module tb_axi_burst_mem_slave;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       ar_valid, ar_ready;
  logic [3:0] ar_id;
  logic [7:0] ar_addr;
  logic [3:0] ar_len;
  logic       r_valid, r_ready;
  logic [7:0] r_data;
  logic [3:0] r_id;
  logic [1:0] r_resp;
  logic       r_last;
  logic       aw_valid, aw_ready;
  logic [3:0] aw_id;
  logic [7:0] aw_addr;
  logic [3:0] aw_len;
  logic       w_valid, w_ready;
  logic [7:0] w_data;
  logic       w_last;
  logic       b_valid, b_ready;
  logic [3:0] b_id;
  logic [1:0] b_resp;

  logic [7:0] mem_m [256];
  logic [7:0] wbuf  [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_burst_mem_slave #(
    .DATA_W(8), .ADDR_W(8), .ID_W(4), .LEN_W(4), .MEM_DEPTH(256)
  ) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_resp(r_resp), .r_last(r_last),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Full write transaction; the model applies the burst rules independently of the DUT
  task automatic do_write(input logic [3:0] id, input logic [7:0] addr, input logic [3:0] len, input int nb);
    int t;
    logic err;
    logic [8:0] a;
    aw_id = id; aw_addr = addr; aw_len = len; aw_valid = 1'b1;
    t = 0;
    while (!aw_ready && t < TMO) begin @(negedge clk); t++; end
    check("aw_ready", 32'(aw_ready), 1);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int k = 0; k < nb; k++) begin
      w_valid = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      w_valid = 1'b1; w_data = wbuf[k]; w_last = (k == nb - 1);
      t = 0;
      while (!w_ready && t < TMO) begin @(negedge clk); t++; end
      check("w_ready", 32'(w_ready), 1);
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    check("w_ready_off", 32'(w_ready), 0);
    err = 1'b0;
    for (int k = 0; k < nb; k++) begin
      a = 9'(addr) + 9'(k);
      if (k > int'(len))   err = 1'b1;
      else if (a >= 9'd256) err = 1'b1;
      else                  mem_m[a[7:0]] = wbuf[k];
    end
    if (nb < int'(len) + 1) err = 1'b1;
    t = 0;
    while (t < TMO) begin
      b_ready = 1'($urandom_range(0, 1));
      if (b_valid && b_ready) break;
      @(negedge clk); t++;
    end
    check("b_valid", 32'(b_valid), 1);
    check("b_id", 32'(b_id), 32'(id));
    check("b_resp", 32'(b_resp), err ? 32'd2 : 32'd0);
    @(negedge clk);
    b_ready = 1'b0;
    check("b_valid_off", 32'(b_valid), 0);
  endtask

  // Full read transaction. mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1
  task automatic do_read(input logic [3:0] id, input logic [7:0] addr, input logic [3:0] len, input int mode);
    int t, k, pi;
    logic held;
    logic [11:0] hv;
    logic [8:0] a;
    ar_id = id; ar_addr = addr; ar_len = len; ar_valid = 1'b1;
    t = 0;
    while (!ar_ready && t < TMO) begin @(negedge clk); t++; end
    check("ar_ready", 32'(ar_ready), 1);
    @(negedge clk);
    ar_valid = 1'b0;
    check("r_first", 32'(r_valid), 1);
    k = 0; t = 0; pi = 0; held = 1'b0; hv = '0;
    while (k <= int'(len) && t < TMO) begin
      if (held) check("r_hold", 32'({r_valid, r_last, r_resp, r_data}), 32'(hv));
      held = 1'b0;
      case (mode)
        0:       r_ready = 1'b1;
        1:       r_ready = 1'($urandom_range(0, 1));
        default: begin r_ready = (pi % 4 == 0) || (pi % 4 == 3); pi++; end
      endcase
      if (r_valid) begin
        if (r_ready) begin
          a = 9'(addr) + 9'(k);
          check("r_data", 32'(r_data), (a < 9'd256) ? 32'(mem_m[a[7:0]]) : 32'd0);
          check("r_resp", 32'(r_resp), (a < 9'd256) ? 32'd0 : 32'd2);
          check("r_last", 32'(r_last), 32'(k == int'(len)));
          check("r_id", 32'(r_id), 32'(id));
          k++;
        end else begin
          held = 1'b1;
          hv = {r_valid, r_last, r_resp, r_data};
        end
      end
      @(negedge clk); t++;
    end
    r_ready = 1'b0;
    check("r_beats", 32'(k), 32'(int'(len) + 1));
    check("r_valid_end", 32'(r_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; r_ready = 0;
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0;
    w_valid = 0; w_data = 0; w_last = 0; b_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({ar_ready, r_valid, r_data, r_id, r_resp, r_last,
                            aw_ready, w_ready, b_valid, b_id, b_resp}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ar_ready_rel", 32'(ar_ready), 1);
    check("aw_ready_rel", 32'(aw_ready), 1);

    // Give every word a known value
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom);
      do_write(4'(b), 8'(b * 16), 4'd15, 16);
    end

    // Basic write then read back
    for (int k = 0; k < 4; k++) wbuf[k] = 8'hA0 + 8'(k);
    do_write(4'd5, 8'h10, 4'd3, 4);
    do_read(4'd3, 8'h10, 4'd3, 0);
    check("a3_model", 32'(mem_m[8'h13]), 32'h0A3);

    // Crossing the top of memory, then stalled read
    do_read(4'd1, 8'hFE, 4'd3, 0);
    do_read(4'd2, 8'h30, 4'd7, 2);

    // Short and long write bursts
    for (int k = 0; k < 4; k++) wbuf[k] = 8'h50 + 8'(k);
    do_write(4'd6, 8'h60, 4'd3, 2);
    for (int k = 0; k < 4; k++) wbuf[k] = 8'h70 + 8'(k);
    do_write(4'd7, 8'h68, 4'd1, 3);
    do_read(4'd4, 8'h60, 4'd11, 1);
    do_write(4'd8, 8'hFF, 4'd1, 2);

    // Reset while beat 2 of 4 is on the bus
    ar_id = 4'd2; ar_addr = 8'h40; ar_len = 4'd3; ar_valid = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0; r_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rvalid", 32'(r_valid), 1);
    check("mid_rdata", 32'(r_data), 32'(mem_m[8'h42]));
    rst = 1'b1;
    #1;
    check("rst_rvalid", 32'(r_valid), 0);
    check("rst_arready", 32'(ar_ready), 0);
    @(negedge clk);
    rst = 1'b0; r_ready = 1'b0;
    @(negedge clk);
    check("rel_arready", 32'(ar_ready), 1);
    check("rel_rvalid", 32'(r_valid), 0);

    // AR and AW together; read beat 1 fetches 0x20 on the edge the write lands
    wbuf[0] = 8'h11;
    do_write(4'd1, 8'h20, 4'd0, 1);
    ar_id = 4'd6; ar_addr = 8'h1F; ar_len = 4'd1; ar_valid = 1'b1;
    aw_id = 4'd7; aw_addr = 8'h20; aw_len = 4'd0; aw_valid = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0; aw_valid = 1'b0;
    check("col_rvalid", 32'(r_valid), 1);
    check("col_wready", 32'(w_ready), 1);
    check("col_beat0", 32'(r_data), 32'(mem_m[8'h1F]));
    r_ready = 1'b1; w_valid = 1'b1; w_data = 8'h55; w_last = 1'b1;
    @(negedge clk);
    w_valid = 1'b0; w_last = 1'b0;
    check("col_old", 32'(r_data), 32'h11);
    check("col_last", 32'(r_last), 1);
    check("col_bvalid", 32'(b_valid), 1);
    check("col_bid", 32'(b_id), 7);
    check("col_bresp", 32'(b_resp), 0);
    b_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0; b_ready = 1'b0;
    check("col_rdone", 32'(r_valid), 0);
    check("col_bdone", 32'(b_valid), 0);
    mem_m[8'h20] = 8'h55;
    do_read(4'd9, 8'h20, 4'd0, 0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [7:0] ra;
      logic [3:0] rl;
      int nb;
      ra = 8'($urandom);
      rl = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(rl) + 3)) : int'(rl) + 1;
        for (int k = 0; k < nb; k++) wbuf[k] = 8'($urandom);
        do_write(4'($urandom), ra, rl, nb);
      end else begin
        do_read(4'($urandom), ra, rl, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
